// File: rtl/mem_data_access_pkg.sv
// mem_data_access_pkg: operation codes and shared constants for the memory-access stage.
// Revision: 1.0
`default_nettype none

package mem_data_access_pkg;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;
  localparam logic [7:0] EXE_LL_OP  = 8'b11110000;
  localparam logic [7:0] EXE_SC_OP  = 8'b11111000;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [5:0]  NO_STALL   = 6'b000000;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_data_access_if.sv
// mem_data_access_if: req/ack data bus between the memory stage (master) and memory (slave).
// Revision: 1.0
`default_nettype none

interface mem_data_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

`default_nettype wire

// File: rtl/mem_data_access_lane_align.sv
// mem_lane_align: byte-lane select, store replication, load extraction and alignment check.
// Revision: 1.0
`default_nettype none

module mem_lane_align
  import mem_data_access_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
)(
  input  logic [7:0]  i_aluop,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_reg2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_word,
  output logic        o_misalign,
  output logic        o_is_load,
  output logic        o_is_store
);

  logic [1:0]  w_bidx;
  logic        w_hidx;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // Big-endian flips the lane order: byte 0 lives in bits [31:24].
    w_bidx       = BIG_ENDIAN ? ~i_addr_lo : i_addr_lo;
    w_hidx       = BIG_ENDIAN ? ~i_addr_lo[1] : i_addr_lo[1];
    w_byte       = i_rdata[{w_bidx, 3'b000} +: 8];
    w_half       = i_rdata[{w_hidx, 4'b0000} +: 16];
    o_sel        = 4'b0000;
    o_store_word = i_reg2;
    o_load_word  = i_rdata;
    o_misalign   = 1'b0;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    case (i_aluop)
      EXE_LB_OP, EXE_LBU_OP: begin
        o_is_load   = 1'b1;
        o_sel       = 4'b0001 << w_bidx;
        o_load_word = (i_aluop == EXE_LB_OP) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        o_is_load   = 1'b1;
        o_misalign  = i_addr_lo[0];
        o_sel       = w_hidx ? 4'b1100 : 4'b0011;
        o_load_word = (i_aluop == EXE_LH_OP) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      EXE_LW_OP, EXE_LL_OP: begin
        o_is_load  = 1'b1;
        o_misalign = |i_addr_lo;
        o_sel      = 4'b1111;
      end
      EXE_SB_OP: begin
        o_is_store   = 1'b1;
        o_sel        = 4'b0001 << w_bidx;
        o_store_word = {4{i_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        o_is_store   = 1'b1;
        o_misalign   = i_addr_lo[0];
        o_sel        = w_hidx ? 4'b1100 : 4'b0011;
        o_store_word = {2{i_reg2[15:0]}};
      end
      EXE_SW_OP, EXE_SC_OP: begin
        o_is_store = 1'b1;
        o_misalign = |i_addr_lo;
        o_sel      = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_data_access.sv
// mem_data_access: memory-access stage datapath and data-bus master with LL/SC support.
// Revision: 1.0
`default_nettype none

module mem_data_access
  import mem_data_access_pkg::*;
#(
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic [7:0]        aluop_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  mem_data_access_if.master dbus,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              stallreq_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              bus_err_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_WAIT = 2'd2} state_t;

  state_t          r_state, w_next;
  logic            r_req, r_we, r_llbit, r_wreg;
  logic [31:0]     r_addr, r_bwdata, r_rd_buf, r_alu;
  logic [3:0]      r_sel;
  logic [7:0]      r_op;
  logic [1:0]      r_alo;
  logic [4:0]      r_wd;
  logic [TW-1:0]   r_timer;

  logic [7:0]  w_op;
  logic [1:0]  w_alo;
  logic [3:0]  w_sel;
  logic [31:0] w_store_word, w_load_word, w_result;
  logic        w_misalign, w_is_load, w_is_store, w_is_sc, w_is_ll, w_start, w_timeout;

  // Once a bus cycle is issued the latched op drives lane extraction.
  assign w_op  = (r_state == S_IDLE) ? aluop_i : r_op;
  assign w_alo = (r_state == S_IDLE) ? addr_i[1:0] : r_alo;

  mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .i_aluop      (w_op),
    .i_addr_lo    (w_alo),
    .i_reg2       (reg2_i),
    .i_rdata      (dbus.rdata),
    .o_sel        (w_sel),
    .o_store_word (w_store_word),
    .o_load_word  (w_load_word),
    .o_misalign   (w_misalign),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store)
  );

  assign w_is_sc   = (w_op == EXE_SC_OP);
  assign w_is_ll   = (w_op == EXE_LL_OP);
  assign w_result  = w_is_sc ? 32'd1 : (w_is_load ? w_load_word : r_alu);
  assign w_start   = (r_state == S_IDLE) && (w_is_load || w_is_store) && !w_misalign
                     && !flush_i && !(w_is_sc && !r_llbit);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_BUSY) && !flush_i
                     && !dbus.ack && (r_timer == TIMER_LAST);

  always_comb begin
    w_next     = r_state;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = 1'b0;
    adel_o     = 1'b0;
    ades_o     = 1'b0;
    bus_err_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_load || w_is_store) begin
          if (w_misalign) begin
            adel_o = w_is_load;
            ades_o = w_is_store;
            wreg_o = 1'b0;
          end else if (flush_i) begin
            wreg_o = 1'b0;
          end else if (w_is_sc && !r_llbit) begin
            wdata_o = ZERO_WORD;
          end else begin
            stallreq_o = 1'b1;
            wreg_o     = wreg_i && w_is_store && !w_is_sc;
            w_next     = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        wd_o    = r_wd;
        wdata_o = w_result;
        wreg_o  = 1'b0;
        if (flush_i) begin
          w_next = S_IDLE;
        end else if (dbus.ack) begin
          wreg_o = r_wreg;
          w_next = (stall_i == NO_STALL) ? S_IDLE : S_WAIT;
        end else if (w_timeout) begin
          bus_err_o = 1'b1;
          w_next    = S_IDLE;
        end else begin
          stallreq_o = 1'b1;
          wreg_o     = r_wreg && w_is_store && !w_is_sc;
        end
      end
      S_WAIT: begin
        wd_o    = r_wd;
        wreg_o  = r_wreg;
        wdata_o = r_rd_buf;
        if (flush_i) begin
          wreg_o = 1'b0;
          w_next = S_IDLE;
        end else if (stall_i == NO_STALL) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (rst == RST_ENABLE) begin
      w_next     = S_IDLE;
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = ZERO_WORD;
      stallreq_o = 1'b0;
      adel_o     = 1'b0;
      ades_o     = 1'b0;
      bus_err_o  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= ZERO_WORD;
      r_sel    <= 4'b0000;
      r_bwdata <= ZERO_WORD;
      r_rd_buf <= ZERO_WORD;
      r_llbit  <= 1'b0;
      r_timer  <= '0;
      r_op     <= EXE_NOP_OP;
      r_alo    <= 2'b00;
      r_wd     <= 5'd0;
      r_wreg   <= 1'b0;
      r_alu    <= ZERO_WORD;
    end else begin
      r_state <= w_next;
      r_timer <= (r_state == S_BUSY && w_next == S_BUSY) ? r_timer + 1'b1 : '0;
      if (w_start) begin
        r_req    <= 1'b1;
        r_we     <= w_is_store;
        r_addr   <= word_addr(addr_i);
        r_sel    <= w_sel;
        r_bwdata <= w_store_word;
        r_op     <= aluop_i;
        r_alo    <= addr_i[1:0];
        r_wd     <= wd_i;
        r_wreg   <= wreg_i;
        r_alu    <= wdata_i;
      end else if (r_state == S_BUSY && w_next != S_BUSY) begin
        r_req <= 1'b0;
        r_we  <= 1'b0;
      end
      if (r_state == S_BUSY && dbus.ack && !flush_i) begin
        r_rd_buf <= w_result;
      end
      if (flush_i) begin
        r_llbit <= 1'b0;
      end else if (r_state == S_BUSY && dbus.ack && w_is_ll) begin
        r_llbit <= 1'b1;
      end else if (r_state == S_BUSY && dbus.ack && w_is_sc) begin
        r_llbit <= 1'b0;
      end
    end
  end

  assign dbus.req   = r_req;
  assign dbus.we    = r_we;
  assign dbus.addr  = r_addr;
  assign dbus.sel   = r_sel;
  assign dbus.wdata = r_bwdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_data_access.sv
// tb_mem_data_access: directed and randomized checks of the memory-access stage against a reference model.
// Revision: 1.0
`default_nettype none

module tb_mem_data_access;
  import mem_data_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] addr_i, reg2_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, adel_o, ades_o, bus_err_o;

  int checks = 0;
  int errors = 0;
  bit m_llbit = 1'b0;

  mem_data_access_if dbus_if ();

  mem_data_access #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .aluop_i    (aluop_i),
    .addr_i     (addr_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .dbus       (dbus_if),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o),
    .adel_o     (adel_o),
    .ades_o     (ades_o),
    .bus_err_o  (bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 for non-memory ops.
  function automatic int op_size(input logic [7:0] op);
    if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) return 1;
    if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return 2;
    if (op inside {EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP}) return 4;
    return 0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [7:0] op, input logic [1:0] a);
    int sz = op_size(op);
    logic [3:0] top_byte = 4'b1000;
    if (sz == 1) return top_byte >> a;
    if (sz == 2) return (a == 2'd0) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_store(input logic [7:0] op, input logic [31:0] r);
    int sz = op_size(op);
    if (sz == 1) return {4{r[7:0]}};
    if (sz == 2) return {2{r[15:0]}};
    return r;
  endfunction

  // Big-endian: byte k of the word sits (3-k) bytes up from bit 0.
  function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] t;
    int sz = op_size(op);
    if (sz == 4) return rd;
    t = rd >> (8 * ((sz == 1 ? 3 : 2) - int'(a)));
    case (op)
      EXE_LB_OP:  return {{24{t[7]}}, t[7:0]};
      EXE_LBU_OP: return {24'h0, t[7:0]};
      EXE_LH_OP:  return {{16{t[15]}}, t[15:0]};
      default:    return {16'h0, t[15:0]};
    endcase
  endfunction

  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input int delay, input int nstall);
    int          sz;
    bit          ld, st, sc, mis, scfail, start, wr;
    logic [31:0] res, alu;
    logic [4:0]  wd;
    sz     = op_size(op);
    ld     = op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP};
    st     = (sz != 0) && !ld;
    sc     = (op == EXE_SC_OP);
    mis    = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
    scfail = sc && !m_llbit && !mis;
    start  = (sz != 0) && !mis && !scfail;
    wr     = ld || sc || (sz == 0);
    alu    = $urandom;
    wd     = 5'($urandom_range(31));
    aluop_i = op; addr_i = addr; reg2_i = reg2; wd_i = wd; wreg_i = wr; wdata_i = alu;
    stall_i = 6'b0; flush_i = 1'b0; dbus_if.ack = 1'b0; dbus_if.rdata = $urandom;
    #1;
    chk("stallreq_idle", 32'(stallreq_o), 32'(start));
    chk("adel", 32'(adel_o), 32'(ld && mis));
    chk("ades", 32'(ades_o), 32'(st && mis));
    if (!start) begin
      chk("wreg_pass", 32'(wreg_o), 32'(mis ? 1'b0 : wr));
      if (!mis) chk("wdata_pass", wdata_o, scfail ? 32'h0 : alu);
      chk("wd_pass", 32'(wd_o), 32'(wd));
      tick();
      chk("no_req", 32'(dbus_if.req), 32'(0));
      return;
    end
    tick();
    chk("req", 32'(dbus_if.req), 32'(1));
    chk("we", 32'(dbus_if.we), 32'(st));
    chk("addr", dbus_if.addr, {addr[31:2], 2'b00});
    chk("sel", 32'(dbus_if.sel), 32'(exp_sel(op, addr[1:0])));
    if (st) chk("bus_wdata", dbus_if.wdata, exp_store(op, reg2));
    for (int i = 0; i < delay; i++) begin
      chk("busy_stall", 32'(stallreq_o), 32'(1));
      chk("busy_no_err", 32'(bus_err_o), 32'(0));
      tick();
    end
    res = sc ? 32'd1 : exp_load(op, addr[1:0], rdata);
    dbus_if.ack = 1'b1; dbus_if.rdata = rdata;
    stall_i = (nstall > 0) ? 6'b001111 : 6'b000000;
    #1;
    chk("ack_stall", 32'(stallreq_o), 32'(0));
    chk("ack_wreg", 32'(wreg_o), 32'(wr));
    chk("ack_wd", 32'(wd_o), 32'(wd));
    if (ld || sc) chk("ack_wdata", wdata_o, res);
    if (op == EXE_LL_OP) m_llbit = 1'b1;
    else if (sc) m_llbit = 1'b0;
    tick();
    dbus_if.ack = 1'b0; dbus_if.rdata = $urandom;
    #1;
    chk("req_drop", 32'(dbus_if.req), 32'(0));
    if (nstall > 0) begin
      for (int i = 1; i < nstall; i++) begin
        if (ld || sc) chk("wait_wdata", wdata_o, res);
        chk("wait_stall", 32'(stallreq_o), 32'(0));
        tick();
      end
      stall_i = 6'b0;
      #1;
      if (ld || sc) chk("wait_wdata_last", wdata_o, res);
      chk("wait_wreg", 32'(wreg_o), 32'(wr));
      tick();
      chk("no_second_req", 32'(dbus_if.req), 32'(0));
    end
  endtask

  logic [7:0] ops [11] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP,
                           EXE_SH_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP, 8'b00100101};

  initial begin
    rst = 1'b1; stall_i = 6'b0; flush_i = 1'b0; aluop_i = EXE_LW_OP; addr_i = 32'h100;
    reg2_i = 32'h0; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
    tick(); tick();
    chk("rst_req", 32'(dbus_if.req), 32'(0));
    chk("rst_we", 32'(dbus_if.we), 32'(0));
    chk("rst_sel", 32'(dbus_if.sel), 32'(0));
    chk("rst_stall", 32'(stallreq_o), 32'(0));
    chk("rst_wreg", 32'(wreg_o), 32'(0));
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_err", 32'(bus_err_o), 32'(0));
    aluop_i = EXE_NOP_OP;
    tick();
    rst = 1'b0;

    run_op(EXE_LB_OP, 32'h103, 32'h0, 32'h1122_3380, 2, 0);
    run_op(EXE_SH_OP, 32'h202, 32'hAAAA_5678, 32'h0, 1, 0);
    run_op(EXE_LW_OP, 32'h101, 32'h0, 32'h0, 0, 0);
    run_op(EXE_SW_OP, 32'h102, 32'h1234, 32'h0, 0, 0);
    run_op(EXE_LL_OP, 32'h300, 32'h0, 32'hCAFE_0001, 1, 0);
    run_op(EXE_SC_OP, 32'h300, 32'h5, 32'h0, 0, 0);
    run_op(EXE_SC_OP, 32'h300, 32'h5, 32'h0, 0, 0);
    run_op(EXE_LW_OP, 32'h400, 32'h0, 32'h8765_4321, 1, 3);
    run_op(EXE_LHU_OP, 32'h402, 32'h0, 32'h1234_F00D, 3, 2);

    // Bus never answers: error on the 4th busy cycle.
    aluop_i = EXE_LW_OP; addr_i = 32'h500; wreg_i = 1'b1; stall_i = 6'b0;
    #1;
    chk("to_start", 32'(stallreq_o), 32'(1));
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("to_wait_err", 32'(bus_err_o), 32'(0));
      chk("to_wait_stall", 32'(stallreq_o), 32'(1));
    end
    tick();
    chk("to_err", 32'(bus_err_o), 32'(1));
    chk("to_stall", 32'(stallreq_o), 32'(0));
    chk("to_wreg", 32'(wreg_o), 32'(0));
    aluop_i = EXE_NOP_OP;
    tick();
    chk("to_req", 32'(dbus_if.req), 32'(0));
    chk("to_err_pulse", 32'(bus_err_o), 32'(0));

    // Flush beats a simultaneous ack and clears the LL bit.
    run_op(EXE_LL_OP, 32'h600, 32'h0, 32'h1, 0, 0);
    aluop_i = EXE_LW_OP; addr_i = 32'h700; wreg_i = 1'b1;
    #1;
    tick();
    flush_i = 1'b1; dbus_if.ack = 1'b1;
    #1;
    chk("fl_wreg", 32'(wreg_o), 32'(0));
    chk("fl_stall", 32'(stallreq_o), 32'(0));
    tick();
    flush_i = 1'b0; dbus_if.ack = 1'b0; aluop_i = EXE_NOP_OP;
    #1;
    chk("fl_req", 32'(dbus_if.req), 32'(0));
    m_llbit = 1'b0;
    run_op(EXE_SC_OP, 32'h600, 32'h9, 32'h0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      run_op(ops[$urandom_range(10)], $urandom, $urandom, $urandom,
             int'($urandom_range(3)), int'($urandom_range(2)));
    end

    aluop_i = EXE_NOP_OP;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
